// File: rtl/spram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM.
// Drops the RAM into standby after a run of idle cycles.
module spram_arbiter #(
    parameter int IDLE_LIMIT  = 64,
    parameter int WAKE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic        p0_we,
    input  logic [13:0] p0_addr,
    input  logic [15:0] p0_wdata,
    input  logic [1:0]  p0_wmask,
    output logic [15:0] p0_rdata,
    output logic        p0_rvalid,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic        p1_we,
    input  logic [13:0] p1_addr,
    input  logic [15:0] p1_wdata,
    input  logic [1:0]  p1_wmask,
    output logic [15:0] p1_rdata,
    output logic        p1_rvalid,
    output logic [13:0] ram_addr,
    output logic [15:0] ram_datain,
    output logic [3:0]  ram_maskwren,
    output logic        ram_wren,
    output logic        ram_cs,
    output logic        ram_standby,
    output logic        ram_sleep,
    output logic        ram_poweroff,
    input  logic [15:0] ram_dataout
);

    typedef enum logic [1:0] {
        ACTIVE,
        STANDBY,
        WAKE
    } state_t;

    localparam int IW = $clog2(IDLE_LIMIT + 2);
    localparam logic [IW-1:0] LIM = IW'(IDLE_LIMIT);
    localparam logic [7:0] WLAST = 8'(WAKE_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nx;
    logic            r_ptr;
    logic [IW-1:0]   r_idle;
    logic [IW-1:0]   w_idle_nx;
    logic [IW-1:0]   w_idle_inc;
    logic [7:0]      r_wcnt;
    logic [7:0]      w_wcnt_nx;
    logic            r_rv0;
    logic            r_rv1;
    logic            w_any;
    logic            w_act;
    logic            w_g0;
    logic            w_g1;
    logic [1:0]      w_mask;

    assign w_any      = p0_valid | p1_valid;
    assign w_act      = (r_state == ACTIVE) && !rst;
    assign w_g0       = w_act && p0_valid && (!p1_valid || !r_ptr);
    assign w_g1       = w_act && p1_valid && (!p0_valid || r_ptr);
    assign w_idle_inc = r_idle + IW'(1);

    assign p0_ready     = w_g0;
    assign p1_ready     = w_g1;
    assign p0_rdata     = ram_dataout;
    assign p1_rdata     = ram_dataout;
    assign p0_rvalid    = r_rv0;
    assign p1_rvalid    = r_rv1;
    assign ram_standby  = (r_state == STANDBY);
    assign ram_sleep    = 1'b0;
    assign ram_poweroff = 1'b1;

    // Route the granted port onto the RAM, all-zero when nothing is granted
    always_comb begin
        ram_cs     = 1'b0;
        ram_wren   = 1'b0;
        ram_addr   = '0;
        ram_datain = '0;
        w_mask     = '0;
        if (w_g0) begin
            ram_cs     = 1'b1;
            ram_wren   = p0_we;
            ram_addr   = p0_addr;
            ram_datain = p0_wdata;
            w_mask     = p0_wmask;
        end else if (w_g1) begin
            ram_cs     = 1'b1;
            ram_wren   = p1_we;
            ram_addr   = p1_addr;
            ram_datain = p1_wdata;
            w_mask     = p1_wmask;
        end
        ram_maskwren = {w_mask[1], w_mask[1], w_mask[0], w_mask[0]};
    end

    // Power-state sequencing: idle countdown into standby, timed wake-up
    always_comb begin
        w_state_nx = r_state;
        w_idle_nx  = r_idle;
        w_wcnt_nx  = r_wcnt;
        unique case (r_state)
            ACTIVE: begin
                if (w_any) begin
                    w_idle_nx = '0;
                end else if (IDLE_LIMIT > 0 && !(r_rv0 || r_rv1)) begin
                    if (w_idle_inc == LIM) begin
                        w_state_nx = STANDBY;
                        w_idle_nx  = '0;
                    end else begin
                        w_idle_nx = w_idle_inc;
                    end
                end
            end
            STANDBY: begin
                if (w_any) begin
                    w_state_nx = WAKE;
                    w_wcnt_nx  = '0;
                end
            end
            WAKE: begin
                if (r_wcnt == WLAST) begin
                    w_state_nx = ACTIVE;
                    w_wcnt_nx  = '0;
                end else begin
                    w_wcnt_nx = r_wcnt + 8'd1;
                end
            end
            default: begin
                w_state_nx = ACTIVE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACTIVE;
            r_idle  <= '0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idle  <= w_idle_nx;
            r_wcnt  <= w_wcnt_nx;
        end
    end

    // Round-robin pointer flips to the other port after every grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (w_g0) begin
            r_ptr <= 1'b1;
        end else if (w_g1) begin
            r_ptr <= 1'b0;
        end
    end

    // Read-data valid strobes, one cycle behind the read grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rv0 <= 1'b0;
            r_rv1 <= 1'b0;
        end else begin
            r_rv0 <= w_g0 && !p0_we;
            r_rv1 <= w_g1 && !p1_we;
        end
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: SPRAM model, behavioural reference,
// directed scenarios with hand-computed literals.
module tb_spram_arbiter;

    localparam int LIM = 8;
    localparam int WK  = 4;

    logic        clk;
    logic        rst;
    logic        p0_valid, p0_we, p1_valid, p1_we;
    logic [13:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic [1:0]  p0_wmask, p1_wmask;
    logic        p0_ready, p1_ready, p0_rvalid, p1_rvalid;
    logic [15:0] p0_rdata, p1_rdata;
    logic [13:0] ram_addr;
    logic [15:0] ram_datain;
    logic [3:0]  ram_maskwren;
    logic        ram_wren, ram_cs, ram_standby, ram_sleep, ram_poweroff;
    logic [15:0] ram_dataout;

    logic        n_p0_ready, n_p1_ready, n_p0_rvalid, n_p1_rvalid;
    logic [15:0] n_p0_rdata, n_p1_rdata;
    logic [13:0] n_ram_addr;
    logic [15:0] n_ram_datain;
    logic [3:0]  n_ram_maskwren;
    logic        n_ram_wren, n_ram_cs, n_standby, n_sleep, n_poweroff;

    int n_chk = 0;
    int n_err = 0;

    spram_arbiter #(.IDLE_LIMIT(LIM), .WAKE_CYCLES(WK)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
        .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
        .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .ram_addr(ram_addr), .ram_datain(ram_datain),
        .ram_maskwren(ram_maskwren), .ram_wren(ram_wren),
        .ram_cs(ram_cs), .ram_standby(ram_standby),
        .ram_sleep(ram_sleep), .ram_poweroff(ram_poweroff),
        .ram_dataout(ram_dataout)
    );

    spram_arbiter #(.IDLE_LIMIT(0), .WAKE_CYCLES(WK)) u_nosb (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(n_p0_ready), .p0_we(p0_we),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
        .p0_rdata(n_p0_rdata), .p0_rvalid(n_p0_rvalid),
        .p1_valid(p1_valid), .p1_ready(n_p1_ready), .p1_we(p1_we),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
        .p1_rdata(n_p1_rdata), .p1_rvalid(n_p1_rvalid),
        .ram_addr(n_ram_addr), .ram_datain(n_ram_datain),
        .ram_maskwren(n_ram_maskwren), .ram_wren(n_ram_wren),
        .ram_cs(n_ram_cs), .ram_standby(n_standby),
        .ram_sleep(n_sleep), .ram_poweroff(n_poweroff),
        .ram_dataout(16'h0000)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SPRAM behaviour: nibble write enables, registered read data
    logic [15:0] mem [0:16383];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_wren) begin
                for (int i = 0; i < 4; i++)
                    if (ram_maskwren[i])
                        mem[ram_addr][4*i +: 4] <= ram_datain[4*i +: 4];
            end else begin
                ram_dataout <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
        end
    endtask

    // Reference model: byte memory, mode, idle/wake counts, preference
    logic [15:0] mm [0:16383];
    int          m_mode;
    int          m_idle;
    int          m_wk;
    logic        m_pref, m_pv0, m_pv1;
    logic [15:0] m_pd;

    initial begin
        logic        g0, g1, gw, busy;
        logic [13:0] ga;
        logic [15:0] gd;
        logic [1:0]  gm;
        for (int i = 0; i < 16384; i++) begin
            mm[i]  = 16'h0;
            mem[i] = 16'h0;
        end
        m_mode = 0; m_idle = 0; m_wk = 0;
        m_pref = 0; m_pv0 = 0; m_pv1 = 0; m_pd = 0;
        forever begin
            @(negedge clk);
            chk("nosb_standby", n_standby, 1'b0);
            if (rst) begin
                chk("rst_outs", {p0_ready, p1_ready, ram_cs, ram_wren,
                    p0_rvalid, p1_rvalid, ram_standby}, 0);
                chk("rst_bus", {ram_addr, ram_datain, ram_maskwren}, 0);
                m_mode = 0; m_idle = 0; m_wk = 0;
                m_pref = 0; m_pv0 = 0; m_pv1 = 0;
            end else begin
                g0 = 0; g1 = 0;
                if (m_mode == 0) begin
                    if (p0_valid && p1_valid) begin
                        g1 = m_pref;
                        g0 = !m_pref;
                    end else begin
                        g0 = p0_valid;
                        g1 = p1_valid;
                    end
                end
                gw = 0; ga = 0; gd = 0; gm = 0;
                if (g0) begin
                    gw = p0_we; ga = p0_addr; gd = p0_wdata; gm = p0_wmask;
                end else if (g1) begin
                    gw = p1_we; ga = p1_addr; gd = p1_wdata; gm = p1_wmask;
                end
                chk("ready", {p0_ready, p1_ready}, {g0, g1});
                chk("cs", ram_cs, g0 | g1);
                chk("wren", ram_wren, gw);
                chk("addr", ram_addr, ga);
                chk("datain", ram_datain, gd);
                chk("mask", ram_maskwren, {gm[1], gm[1], gm[0], gm[0]});
                chk("rvalid", {p0_rvalid, p1_rvalid}, {m_pv0, m_pv1});
                if (m_pv0) chk("p0_rdata", p0_rdata, m_pd);
                if (m_pv1) chk("p1_rdata", p1_rdata, m_pd);
                chk("standby", ram_standby, m_mode == 1);
                chk("power", {ram_sleep, ram_poweroff}, 2'b01);
                busy = m_pv0 | m_pv1;
                m_pv0 = g0 && !gw;
                m_pv1 = g1 && !gw;
                if ((g0 || g1) && !gw) m_pd = mm[ga];
                if ((g0 || g1) && gw) begin
                    if (gm[0]) mm[ga][7:0]  = gd[7:0];
                    if (gm[1]) mm[ga][15:8] = gd[15:8];
                end
                if (g0) m_pref = 1;
                if (g1) m_pref = 0;
                if (m_mode == 0) begin
                    if (p0_valid || p1_valid) begin
                        m_idle = 0;
                    end else if (!busy && LIM > 0) begin
                        m_idle++;
                        if (m_idle == LIM) begin
                            m_mode = 1;
                            m_idle = 0;
                        end
                    end
                end else if (m_mode == 1) begin
                    if (p0_valid || p1_valid) begin
                        m_mode = 2;
                        m_wk = 0;
                    end
                end else begin
                    m_wk++;
                    if (m_wk == WK) m_mode = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic we,
                        input logic [13:0] a, input logic [15:0] d,
                        input logic [1:0] m);
        p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = d; p0_wmask = m;
    endtask

    task automatic drv1(input logic v, input logic we,
                        input logic [13:0] a, input logic [15:0] d,
                        input logic [1:0] m);
        p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = d; p1_wmask = m;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        #2;
        chk("init_ready", {p0_ready, p1_ready, ram_cs}, 0);
        tick();
        do_reset();

        // p0 full-mask write, then read back
        drv0(1, 1, 14'h0010, 16'hBEEF, 2'b11);
        #2;
        chk("w0_ready", p0_ready, 1'b1);
        chk("w0_mask", ram_maskwren, 4'hF);
        tick();
        drv0(1, 0, 14'h0010, 16'h0000, 2'b00);
        #2;
        chk("r0_ready", {p0_ready, ram_cs, ram_wren}, 3'b110);
        tick();
        drv0(0, 0, 0, 0, 0);
        #2;
        chk("r0_rvalid", p0_rvalid, 1'b1);
        chk("r0_rdata", p0_rdata, 16'hBEEF);
        tick();
        #2;
        chk("r0_rvalid_off", p0_rvalid, 1'b0);

        // p1 low-byte write over 0xBEEF, then read back
        drv1(1, 1, 14'h0010, 16'h1234, 2'b01);
        #2;
        chk("w1_mask", ram_maskwren, 4'h3);
        tick();
        drv1(1, 0, 14'h0010, 16'h0000, 2'b00);
        tick();
        drv1(0, 0, 0, 0, 0);
        #2;
        chk("r1_rdata", {p1_rvalid, p1_rdata}, {1'b1, 16'hBE34});
        tick();

        // Both ports reading continuously from reset: strict alternation
        do_reset();
        drv0(1, 0, 14'h0010, 0, 0);
        drv1(1, 0, 14'h0011, 0, 0);
        for (int i = 0; i < 6; i++) begin
            #2;
            chk("alt_ready", {p0_ready, p1_ready},
                (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i > 0)
                chk("alt_rvalid", {p0_rvalid, p1_rvalid},
                    (i % 2 == 1) ? 2'b10 : 2'b01);
            tick();
        end
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        #2;
        chk("alt_last_rv", {p0_rvalid, p1_rvalid}, 2'b01);
        tick();

        // Contention with write then read-after-write on the other port
        do_reset();
        drv0(1, 1, 14'h0020, 16'hA5A5, 2'b11);
        drv1(1, 0, 14'h0020, 0, 0);
        #2;
        chk("raw_g0", {p0_ready, p1_ready}, 2'b10);
        tick();
        drv0(1, 0, 14'h0020, 0, 0);
        #2;
        chk("raw_g1", {p0_ready, p1_ready}, 2'b01);
        tick();
        drv1(0, 0, 0, 0, 0);
        #2;
        chk("raw_rd", {p1_rvalid, p1_rdata}, {1'b1, 16'hA5A5});
        chk("raw_g0b", p0_ready, 1'b1);
        tick();
        drv0(0, 0, 0, 0, 0);
        #2;
        chk("raw_rd0", {p0_rvalid, p0_rdata}, {1'b1, 16'hA5A5});
        tick();

        // Idle into standby, then wake on p1
        do_reset();
        for (int k = 1; k <= LIM; k++) begin
            #2;
            chk("sb_pre", ram_standby, 1'b0);
            tick();
        end
        #2;
        chk("sb_on", ram_standby, 1'b1);
        tick();
        tick();
        drv1(1, 0, 14'h0010, 0, 0);
        #2;
        chk("sb_hold", {ram_standby, p1_ready, ram_cs}, 3'b100);
        tick();
        for (int j = 0; j < WK; j++) begin
            #2;
            chk("wake", {ram_standby, p1_ready, ram_cs}, 3'b000);
            if (j == 1) drv1(0, 0, 14'h0010, 0, 0);
            if (j == 2) drv1(1, 0, 14'h0010, 0, 0);
            tick();
        end
        #2;
        chk("wake_grant", p1_ready, 1'b1);
        tick();
        drv1(0, 0, 0, 0, 0);
        #2;
        chk("wake_rd", {p1_rvalid, p1_rdata}, {1'b1, 16'hBE34});
        tick();

        // Reset right after a read grant kills the pending rvalid
        do_reset();
        drv0(1, 0, 14'h0010, 0, 0);
        #2;
        chk("rr_grant", p0_ready, 1'b1);
        tick();
        rst = 1'b1;
        drv0(0, 0, 0, 0, 0);
        #1;
        chk("rr_kill", {p0_rvalid, p0_ready, ram_cs, ram_wren,
            ram_standby}, 0);
        tick();
        rst = 1'b0;
        #2;
        chk("rr_after", {p0_rvalid, p1_rvalid}, 2'b00);
        tick();
        drv0(1, 1, 14'h0030, 16'h5555, 2'b10);
        #2;
        chk("rr_resume", {p0_ready, ram_maskwren}, {1'b1, 4'hC});
        tick();
        drv0(0, 0, 0, 0, 0);

        // Long idle: standby-disabled instance never enters standby
        do_reset();
        for (int k = 0; k < 1000; k++) tick();
        #2;
        chk("nosb_end", {n_standby, ram_standby}, 2'b01);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
